// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between N requesters and a shared FIFO write port.
// master = requester/FIFO side, slave = arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] din;
    logic               fifo_full;
    logic [N-1:0]       gnt;
    logic               fifo_wr_en;
    logic [WIDTH-1:0]   fifo_din;
    logic [OW-1:0]      owner;
    logic [15:0]        stall_cnt;

    modport master (
        output req, din, fifo_full,
        input  gnt, fifo_wr_en, fifo_din, owner, stall_cnt
    );

    modport slave (
        input  req, din, fifo_full,
        output gnt, fifo_wr_en, fifo_din, owner, stall_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with bounded bursts: one owner keeps the FIFO port
// for up to MAX_BURST writes while others wait, then priority rotates.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state, state_nx;
    logic [OW-1:0] ptr, ptr_nx;
    logic [OW-1:0] owner_r, owner_nx, owner_inc;
    logic [3:0]    burst_cnt, burst_nx;
    logic [15:0]   stall_r;
    logic [N-1:0]  others;
    logic          grant;
    logic [OW-1:0] win;

    // First set bit of r at or after start, wrapping N-1 -> 0.
    function automatic logic [OW-1:0] pick(input logic [N-1:0] r, input logic [OW-1:0] start);
        int idx;
        pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N;
            if (r[idx]) pick = OW'(idx);
        end
    endfunction

    assign owner_inc = OW'((int'(owner_r) + 1) % N);
    assign others    = bus.req & ~(N'(1) << owner_r);

    always_comb begin
        grant    = 1'b0;
        win      = owner_r;
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner_r;
        burst_nx = burst_cnt;
        if (rst && !bus.fifo_full) begin
            if (state == IDLE) begin
                if (|bus.req) begin
                    grant    = 1'b1;
                    win      = pick(bus.req, ptr);
                    state_nx = HOLD;
                    owner_nx = win;
                    burst_nx = 4'd1;
                end
            end else if (bus.req[owner_r]) begin
                grant = 1'b1;
                if (burst_cnt < 4'(MAX_BURST)) begin
                    burst_nx = burst_cnt + 4'd1;
                end else if (|others) begin
                    ptr_nx   = owner_inc;
                    win      = pick(others, owner_inc);
                    owner_nx = win;
                    burst_nx = 4'd1;
                end else begin
                    // sole requester: restart the burst without an idle bubble
                    burst_nx = 4'd1;
                end
            end else begin
                ptr_nx = owner_inc;
                if (|bus.req) begin
                    grant    = 1'b1;
                    win      = pick(bus.req, owner_inc);
                    owner_nx = win;
                    burst_nx = 4'd1;
                end else begin
                    state_nx = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner_r   <= '0;
            burst_cnt <= '0;
            stall_r   <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            owner_r   <= owner_nx;
            burst_cnt <= burst_nx;
            if (|bus.req && bus.fifo_full && stall_r != 16'hFFFF)
                stall_r <= stall_r + 16'd1;
        end
    end

    assign bus.gnt        = grant ? (N'(1) << win) : '0;
    assign bus.fifo_wr_en = grant;
    assign bus.fifo_din   = grant ? bus.din[win*WIDTH +: WIDTH] : '0;
    assign bus.owner      = owner_r;
    assign bus.stall_cnt  = stall_r;
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N, default 4, number of write requesters sharing one FIFO write port (2..8).
REQ-002 Parameter WIDTH, default 8, data width per requester and of the FIFO write port.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive grants to one requester while others wait (1..15).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low; the module is in reset when rst=0 at a rising clk edge.
REQ-006 req  input  N  req[i]=1: requester i holds valid data on its din slice.
REQ-007 din  input  N*WIDTH  requester data, bits [i*WIDTH +: WIDTH] belong to requester i.
REQ-008 fifo_full  input  1  FIFO full flag; no write may be issued while it is 1.
REQ-009 gnt  output  N  one-hot-or-zero, combinational; gnt[i]=1 means requester i's data is written at the coming edge.
REQ-010 fifo_wr_en  output  1  FIFO write enable, combinational, equals |gnt.
REQ-011 fifo_din  output  WIDTH  FIFO write data, din slice of the granted requester, 0 when no grant.
REQ-012 owner  output  clog2(N)  index of current burst owner (debug).
REQ-013 stall_cnt  output  16  saturating count of cycles with |req=1 and fifo_full=1.

Function
REQ-014 State machine, two states: IDLE (no owner), HOLD (owner valid, burst_cnt = grants issued to owner in current burst).
REQ-015 gnt SHALL be all-zero whenever fifo_full=1, rst=0, or req=0.
REQ-016 IDLE, fifo_full=0, req!=0: grant the first requesting index searching ptr, ptr+1, ... modulo N; next state HOLD, owner=winner, burst_cnt=1.
REQ-017 HOLD, fifo_full=0, req[owner]=1, burst_cnt<MAX_BURST: grant owner, burst_cnt+1.
REQ-018 HOLD, fifo_full=0, req[owner]=1, burst_cnt=MAX_BURST, another req set: ptr=owner+1 mod N, grant first requester from ptr excluding owner; owner=that winner, burst_cnt=1.
REQ-019 HOLD, burst_cnt=MAX_BURST, only owner requesting: owner keeps grant, burst_cnt restarts at 1 (no idle bubble).
REQ-020 HOLD, req[owner]=0: ptr=owner+1 mod N; if another req and fifo_full=0 grant first from ptr (new owner, burst_cnt=1), else next state IDLE.
REQ-021 HOLD, fifo_full=1: no grant, owner, burst_cnt and state unchanged (full stall does not consume burst).
REQ-022 Exactly one write per cycle maximum; a requester receives at most one grant per cycle.
REQ-023 Wrap-around: index N-1 followed by 0 in every priority search.
REQ-024 stall_cnt increments by 1 per qualifying cycle, holds at 16'hFFFF.
REQ-025 No combinational path from gnt back to req is assumed; gnt depends only on req, fifo_full, rst and registered state.

Reset
REQ-026 With rst=0 at an edge: state=IDLE, ptr=0, owner=0, burst_cnt=0, stall_cnt=0.
REQ-027 While rst=0: gnt=0, fifo_wr_en=0, fifo_din=0, regardless of req.
REQ-028 Reset mid-burst aborts the burst; the first grant after release follows REQ-016 with ptr=0.

Verification
REQ-029 Single requester: req=4'b0100, din[2]=8'hA0..A5 over 6 cycles, fifo_full=0 -> 6 consecutive grants to 2, fifo_din in order, no bubble.
REQ-030 All four requesting continuously, MAX_BURST=4, fifo_full=0 -> grant order 0x4, 1x4, 2x4, 3x4, 0x4; owner tracks.
REQ-031 req=4'b1001 after owner=3 burst ends -> next grant to 0 (wrap-around), then 3 after 0's burst.
REQ-032 Owner 1 at burst_cnt=2, fifo_full=1 for 5 cycles -> gnt=0, fifo_wr_en=0, stall_cnt=5; after release owner 1 gets 2 more grants.
REQ-033 rst=0 asserted during owner 2 burst -> next cycle gnt=0, stall_cnt=0; after release with req=4'b1111 first grant to 0.
REQ-034 Scoreboard: every fifo_wr_en cycle matches fifo_din to the granted requester's din; never fifo_wr_en with fifo_full=1; gnt always one-hot-or-zero.
